// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared widths and word type for the async FIFO, its read drain and the formal bench
package async_fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// fifo_rd_skid_buf: 2-entry register FIFO with registered head and occupancy level
module fifo_rd_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   level
);
  logic [W-1:0] tail;
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      head  <= (push && (level == 2'd0 || (level == 2'd1 && pop))) ? din :
               (pop && level == 2'd2) ? tail : head;
      tail  <= (push && ((level == 2'd1 && !pop) || (level == 2'd2 && pop))) ? din : tail;
      level <= level + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/async_fifo_rd_drain.sv
// async_fifo_rd_drain: drains the FIFO read port into a 2-deep buffer and streams it with burst framing
module async_fifo_rd_drain #(
  parameter int DATA_WIDTH = async_fifo_pkg::DATA_WIDTH,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [1:0]            buf_level
);
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(BURST_LEN - 1);
  logic [IW-1:0] beat_idx;
  logic hs;
  assign rinc      = !rrst && !rempty && buf_level != 2'd2;
  assign out_valid = buf_level != 2'd0;
  assign hs        = out_valid && out_ready;
  assign out_last  = out_valid && beat_idx == LAST;
  fifo_rd_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk  (rclk),
    .rst  (rrst),
    .push (rinc),
    .pop  (hs),
    .din  (rdata),
    .head (out_data),
    .level(buf_level)
  );
  always_ff @(posedge rclk) begin
    if (rrst) begin
      beat_idx   <= '0;
      beat_count <= '0;
    end else if (hs) begin
      beat_idx   <= (beat_idx == LAST) ? '0 : beat_idx + 1'b1;
      beat_count <= beat_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// tb_async_fifo_rd_drain: directed self-checking bench with a queue model of the FIFO read port
module tb_async_fifo_rd_drain;
  logic        rclk = 0, rrst = 1, rempty = 1, rinc, out_valid, out_ready = 0, out_last;
  logic [7:0]  rdata = 0, out_data;
  logic [15:0] beat_count;
  logic [1:0]  buf_level;
  logic        rempty_w = 1, rinc_w, out_valid_w, out_ready_w = 1, out_last_w;
  logic [7:0]  out_data_w;
  logic [3:0]  beat_count_w;
  logic [1:0]  buf_level_w;
  int tests = 0, fails = 0;
  int cyc = 0, pops, viol, maxlvl, first_rinc, first_valid, stall_bad;
  logic [7:0] fq[$];
  logic [7:0] rx_d[$];
  logic       rx_l[$];
  int         rx_cyc[$];

  async_fifo_rd_drain u_dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .beat_count(beat_count), .buf_level(buf_level)
  );
  async_fifo_rd_drain #(.CNT_WIDTH(4)) u_wrap (
    .rclk(rclk), .rrst(rrst), .rempty(rempty_w), .rdata(8'hAA), .rinc(rinc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
    .out_last(out_last_w), .beat_count(beat_count_w), .buf_level(buf_level_w)
  );

  always #5 rclk = ~rclk;

  task automatic sync_fifo();
    rempty = (fq.size() == 0);
    rdata  = rempty ? 8'h00 : fq[0];
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    sync_fifo();
  endtask

  task automatic clear_log();
    rx_d.delete(); rx_l.delete(); rx_cyc.delete();
    pops = 0; viol = 0; maxlvl = 0; first_rinc = -1; first_valid = -1; stall_bad = 0;
  endtask

  task automatic tick();
    logic did;
    @(negedge rclk);
    if (rinc && rempty) viol++;
    if (int'(buf_level) > maxlvl) maxlvl = int'(buf_level);
    if (rinc) begin
      pops++;
      if (first_rinc < 0) first_rinc = cyc;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && out_ready) begin
      rx_d.push_back(out_data); rx_l.push_back(out_last); rx_cyc.push_back(cyc);
    end
    did = rinc;
    @(posedge rclk); #1;
    if (did) void'(fq.pop_front());
    cyc++;
    sync_fifo();
  endtask

  task automatic test_reset();
    int bad = 0;
    rrst = 1;
    repeat (2) @(posedge rclk);
    #1 rrst = 0;
    #3;
    tests++;
    if (out_data !== 8'h00 || out_last !== 1'b0 || buf_level !== 2'd0) begin
      fails++;
      $display("FAIL reset_state: out_data=%h out_last=%b buf_level=%0d, required 00/0/0", out_data, out_last, buf_level);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge rclk);
      if (rinc !== 1'b0 || out_valid !== 1'b0 || beat_count !== 16'd0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_idle: %0d idle cycles had rinc/out_valid/beat_count nonzero, required 0", bad);
    end
    @(posedge rclk); #1;
  endtask

  task automatic test_stream();
    logic [7:0] e;
    clear_log();
    out_ready = 1;
    load(8'h10, 8);
    repeat (12) tick();
    tests++;
    if (first_valid !== first_rinc + 1) begin
      fails++;
      $display("FAIL stream_latency: first valid cycle %0d, required %0d", first_valid, first_rinc + 1);
    end
    tests++;
    if (rx_d.size() != 8) begin
      fails++;
      $display("FAIL stream_count: got %0d beats, required 8", rx_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = 8'h10 + 8'(i);
        tests++;
        if (rx_d[i] !== e || rx_l[i] !== (i == 3 || i == 7) || rx_cyc[i] != first_rinc + 1 + i) begin
          fails++;
          $display("FAIL stream_beat%0d: data=%h last=%b cyc=%0d, required %h/%b/%0d",
                   i, rx_d[i], rx_l[i], rx_cyc[i], e, (i == 3 || i == 7), first_rinc + 1 + i);
        end
      end
    end
    tests++;
    if (beat_count !== 16'd8) begin
      fails++;
      $display("FAIL stream_beat_count: %0d, required 8", beat_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    clear_log();
    out_ready = 0;
    load(8'h20, 5);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid && out_data !== 8'h20) stall_bad++;
    end
    tests++;
    if (pops != 2 || buf_level !== 2'd2 || rinc !== 1'b0 || out_data !== 8'h20 || stall_bad != 0) begin
      fails++;
      $display("FAIL bp_stall: pops=%0d level=%0d rinc=%b data=%h unstable=%0d, required 2/2/0/20/0",
               pops, buf_level, rinc, out_data, stall_bad);
    end
    out_ready = 1;
    tick();
    #3;
    tests++;
    if (rinc !== 1'b1) begin
      fails++;
      $display("FAIL bp_rinc_resume: rinc=%b, required 1", rinc);
    end
    repeat (15) tick();
    tests++;
    if (rx_d.size() != 5) begin
      fails++;
      $display("FAIL bp_count: got %0d beats, required 5", rx_d.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        e = 8'h20 + 8'(i);
        tests++;
        if (rx_d[i] !== e || rx_l[i] !== (i == 3)) begin
          fails++;
          $display("FAIL bp_beat%0d: data=%h last=%b, required %h/%b", i, rx_d[i], rx_l[i], e, (i == 3));
        end
      end
    end
  endtask

  task automatic test_alternate();
    logic [7:0] e;
    int bad = 0;
    clear_log();
    load(8'h30, 8);
    for (int i = 0; i < 40; i++) begin
      out_ready = i[0];
      tick();
    end
    out_ready = 1;
    tests++;
    if (rx_d.size() != 8) begin
      fails++;
      $display("FAIL alt_count: got %0d beats, required 8", rx_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = 8'h30 + 8'(i);
        if (rx_d[i] !== e) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL alt_order: %0d beats out of order, required 0", bad);
      end
    end
    tests++;
    if (maxlvl > 2 || viol != 0) begin
      fails++;
      $display("FAIL alt_rules: max level %0d, rinc-while-empty %0d, required <=2 and 0", maxlvl, viol);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    clear_log();
    out_ready = 1;
    load(8'h3F, 1);
    repeat (3) tick();
    out_ready = 0;
    load(8'h40, 4);
    for (int i = 0; i < 10 && buf_level != 2'd2; i++) tick();
    tests++;
    if (buf_level !== 2'd2) begin
      fails++;
      $display("FAIL rst_fill_timeout: level=%0d, required 2", buf_level);
    end
    rrst = 1;
    #1;
    tests++;
    if (rinc !== 1'b0) begin
      fails++;
      $display("FAIL rst_rinc: rinc=%b during reset, required 0", rinc);
    end
    tick();
    rrst = 0;
    #3;
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || beat_count !== 16'd0 || buf_level !== 2'd0) begin
      fails++;
      $display("FAIL rst_outputs: valid=%b data=%h last=%b count=%0d level=%0d, required all 0",
               out_valid, out_data, out_last, beat_count, buf_level);
    end
    clear_log();
    out_ready = 1;
    load(8'h50, 2);
    repeat (10) tick();
    tests++;
    if (rx_d.size() != 4) begin
      fails++;
      $display("FAIL rst_burst_count: got %0d beats, required 4", rx_d.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = (i < 2) ? 8'h42 + 8'(i) : 8'h50 + 8'(i - 2);
        tests++;
        if (rx_d[i] !== e || rx_l[i] !== (i == 3)) begin
          fails++;
          $display("FAIL rst_burst_beat%0d: data=%h last=%b, required %h/%b", i, rx_d[i], rx_l[i], e, (i == 3));
        end
      end
    end
  endtask

  task automatic test_cnt_wrap();
    int hs = 0, t = 0;
    logic h;
    logic [3:0] e;
    rempty_w = 0;
    while (hs < 17 && t < 60) begin
      @(negedge rclk);
      h = out_valid_w && out_ready_w;
      @(posedge rclk); #1;
      t++;
      if (h) begin
        hs++;
        e = 4'(hs % 16);
        if (hs >= 15) begin
          tests++;
          if (beat_count_w !== e) begin
            fails++;
            $display("FAIL wrap_count_after_%0d: %0d, required %0d", hs, beat_count_w, e);
          end
        end
      end
    end
    rempty_w = 1;
    tests++;
    if (hs != 17) begin
      fails++;
      $display("FAIL wrap_timeout: %0d handshakes, required 17", hs);
    end
  endtask

  initial begin
    sync_fifo();
    test_reset();
    test_stream();
    test_backpressure();
    test_alternate();
    test_reset_mid();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
